// File: rtl/multi_counter.sv
`default_nettype none
// ============================================================================
// multi_counter : CH_P independent up/down counters with clear, load,
//                 wrap-or-saturate overflow, sticky overflow and threshold flags
// Revision      : 1.0
// ============================================================================
module multi_counter #(
    parameter int WIDTH_P = 4,
    parameter int CH_P    = 4,
    parameter int INC_W_P = 4,
    parameter int SAT_P   = 0
) (
    input  logic                       clk,
    input  logic                       reset_L,
    input  logic [CH_P-1:0]            en,
    input  logic [CH_P-1:0]            dir,
    input  logic [CH_P*INC_W_P-1:0]    inc,
    input  logic [CH_P-1:0]            clr,
    input  logic [CH_P-1:0]            load,
    input  logic [CH_P*WIDTH_P-1:0]    load_val,
    input  logic [WIDTH_P-1:0]         thr,
    input  logic [CH_P-1:0]            ovf_clr,
    output logic [CH_P*WIDTH_P-1:0]    val,
    output logic [CH_P-1:0]            non_zero,
    output logic [CH_P-1:0]            thr_hit,
    output logic [CH_P-1:0]            ovf
);

    genvar g;
    for (g = 0; g < CH_P; g++) begin : g_ch
        localparam logic [WIDTH_P-1:0] c_max = '1;

        logic [WIDTH_P-1:0] r_val;
        logic               r_ovf;
        logic [WIDTH_P-1:0] w_val_nxt;
        logic               w_wrap;
        logic [WIDTH_P:0]   w_step;
        logic [WIDTH_P:0]   w_sum;
        logic [WIDTH_P:0]   w_diff;

        // One extra bit: carry out of the sum flags overflow, borrow out of the
        // difference flags underflow.
        assign w_step = {{(WIDTH_P+1-INC_W_P){1'b0}}, inc[g*INC_W_P +: INC_W_P]};
        assign w_sum  = {1'b0, r_val} + w_step;
        assign w_diff = {1'b0, r_val} - w_step;

        always_comb begin
            w_val_nxt = r_val;
            w_wrap    = 1'b0;
            if (clr[g]) begin
                w_val_nxt = '0;
            end else if (load[g]) begin
                w_val_nxt = load_val[g*WIDTH_P +: WIDTH_P];
            end else if (en[g]) begin
                if (dir[g]) begin
                    w_wrap    = w_diff[WIDTH_P];
                    w_val_nxt = (w_wrap && (SAT_P != 0)) ? '0 : w_diff[WIDTH_P-1:0];
                end else begin
                    w_wrap    = w_sum[WIDTH_P];
                    w_val_nxt = (w_wrap && (SAT_P != 0)) ? c_max : w_sum[WIDTH_P-1:0];
                end
            end
        end

        always_ff @(posedge clk or negedge reset_L) begin
            if (!reset_L) begin
                r_val <= '0;
                r_ovf <= 1'b0;
            end else begin
                r_val <= w_val_nxt;
                r_ovf <= w_wrap | (r_ovf & ~ovf_clr[g]);
            end
        end

        assign val[g*WIDTH_P +: WIDTH_P] = r_val;
        assign ovf[g]                    = r_ovf;
        assign non_zero[g]               = |r_val;
        assign thr_hit[g]                = (r_val >= thr);
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_counter.sv
`default_nettype none
// ============================================================================
// tb_multi_counter : scoreboard bench driving a wrapping and a saturating
//                    multi_counter with identical stimulus
// Revision         : 1.0
// ============================================================================
module tb_multi_counter;
    localparam int W    = 4;
    localparam int CH   = 4;
    localparam int IW   = 4;
    localparam int MAXV = 15;

    logic              clk = 1'b0;
    logic              reset_L = 1'b0;
    logic [CH-1:0]     en, dir, clr, load, ovf_clr;
    logic [CH*IW-1:0]  inc;
    logic [CH*W-1:0]   load_val;
    logic [W-1:0]      thr;

    logic [CH*W-1:0]   val_w, val_s;
    logic [CH-1:0]     nz_w, nz_s, th_w, th_s, ovf_w, ovf_s;

    multi_counter #(.WIDTH_P(W), .CH_P(CH), .INC_W_P(IW), .SAT_P(0)) u_dut_wrap (
        .clk(clk), .reset_L(reset_L), .en(en), .dir(dir), .inc(inc), .clr(clr),
        .load(load), .load_val(load_val), .thr(thr), .ovf_clr(ovf_clr),
        .val(val_w), .non_zero(nz_w), .thr_hit(th_w), .ovf(ovf_w));

    multi_counter #(.WIDTH_P(W), .CH_P(CH), .INC_W_P(IW), .SAT_P(1)) u_dut_sat (
        .clk(clk), .reset_L(reset_L), .en(en), .dir(dir), .inc(inc), .clr(clr),
        .load(load), .load_val(load_val), .thr(thr), .ovf_clr(ovf_clr),
        .val(val_s), .non_zero(nz_s), .thr_hit(th_s), .ovf(ovf_s));

    always #5 clk = ~clk;

    int mv_w [CH];
    int mo_w [CH];
    int mv_s [CH];
    int mo_s [CH];
    int checks   = 0;
    int failures = 0;
    logic [55:0] sb [$];
    logic [55:0] exp_v;

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin
            mv_w[c] = 0; mo_w[c] = 0; mv_s[c] = 0; mo_s[c] = 0;
        end
    endfunction

    function automatic void step_ch(input int c, input bit sat);
        int v, o, i, ld, r;
        bit set;
        v   = sat ? mv_s[c] : mv_w[c];
        o   = sat ? mo_s[c] : mo_w[c];
        i   = int'(inc[c*IW +: IW]);
        ld  = int'(load_val[c*W +: W]);
        set = 1'b0;
        if (clr[c]) v = 0;
        else if (load[c]) v = ld;
        else if (en[c]) begin
            if (!dir[c]) begin
                r = v + i;
                if (r > MAXV) begin set = 1'b1; v = sat ? MAXV : r - (MAXV + 1); end
                else v = r;
            end else begin
                r = v - i;
                if (r < 0) begin set = 1'b1; v = sat ? 0 : r + MAXV + 1; end
                else v = r;
            end
        end
        o = (set || (o != 0 && !ovf_clr[c])) ? 1 : 0;
        if (sat) begin mv_s[c] = v; mo_s[c] = o; end
        else     begin mv_w[c] = v; mo_w[c] = o; end
    endfunction

    function automatic logic [27:0] pack_mode(input bit sat);
        logic [CH*W-1:0] v;
        logic [CH-1:0]   o, nz, th;
        int x;
        for (int c = 0; c < CH; c++) begin
            x = sat ? mv_s[c] : mv_w[c];
            v[c*W +: W] = x[W-1:0];
            o[c]  = ((sat ? mo_s[c] : mo_w[c]) != 0);
            nz[c] = (x != 0);
            th[c] = (x >= int'(thr));
        end
        return {v, o, nz, th};
    endfunction

    function automatic logic [55:0] expected();
        return {pack_mode(1'b0), pack_mode(1'b1)};
    endfunction

    function automatic logic [55:0] observed();
        return {val_w, ovf_w, nz_w, th_w, val_s, ovf_s, nz_s, th_s};
    endfunction

    // Predict the post-edge state from the inputs now applied, then clock once.
    task automatic tick();
        for (int c = 0; c < CH; c++) begin
            step_ch(c, 1'b0);
            step_ch(c, 1'b1);
        end
        sb.push_back(expected());
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        en = '0; dir = '0; clr = '0; load = '0; ovf_clr = '0; inc = '0; load_val = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        thr     = '0;
        reset_L = 1'b0;
        model_reset();
        #2;
        checks++;
        if (observed() !== expected()) begin
            failures++; $display("FAIL reset_state obs=%h exp=%h", observed(), expected());
        end
        checks++;
        if (th_w !== 4'b1111 || th_s !== 4'b1111) begin
            failures++; $display("FAIL reset_thr0 obs=%b/%b exp=1111", th_w, th_s);
        end
        thr = 4'd8;
        #1;
        checks++;
        if (observed() !== expected()) begin
            failures++; $display("FAIL reset_thr8 obs=%h exp=%h", observed(), expected());
        end
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    task automatic test_wrap();
        clear_inputs();
        en  = 4'b0001;
        inc = 16'h0001;
        for (int k = 0; k < 20; k++) begin
            tick();
            exp_v = sb.pop_front();
            checks++;
            if (observed() !== exp_v) begin
                failures++; $display("FAIL wrap_cycle%0d obs=%h exp=%h", k, observed(), exp_v);
            end
        end
        checks++;
        if (val_w !== 16'h0004 || ovf_w !== 4'b0001 || val_s !== 16'h000F || ovf_s !== 4'b0001) begin
            failures++;
            $display("FAIL wrap_final obs=%h/%b %h/%b exp=0004/0001 000f/0001", val_w, ovf_w, val_s, ovf_s);
        end
    endtask

    task automatic test_sat();
        clear_inputs();
        load = 4'b0010; load_val = 16'h00E0;
        tick();
        exp_v = sb.pop_front(); checks++;
        if (observed() !== exp_v) begin
            failures++; $display("FAIL sat_load obs=%h exp=%h", observed(), exp_v);
        end
        load = '0; en = 4'b0010; inc = 16'h0030;
        for (int k = 0; k < 3; k++) begin
            tick();
            exp_v = sb.pop_front(); checks++;
            if (observed() !== exp_v) begin
                failures++; $display("FAIL sat_up%0d obs=%h exp=%h", k, observed(), exp_v);
            end
        end
        checks++;
        if (val_s[7:4] !== 4'd15 || ovf_s[1] !== 1'b1) begin
            failures++; $display("FAIL sat_top obs=%0d/%b exp=15/1", val_s[7:4], ovf_s[1]);
        end
        dir = 4'b0010; inc = 16'h0070;
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_v = sb.pop_front(); checks++;
            if (observed() !== exp_v) begin
                failures++; $display("FAIL sat_down%0d obs=%h exp=%h", k, observed(), exp_v);
            end
        end
        checks++;
        if (val_s[7:4] !== 4'd0) begin
            failures++; $display("FAIL sat_bottom obs=%0d exp=0", val_s[7:4]);
        end
    endtask

    task automatic test_priority();
        clear_inputs();
        clr = 4'b0100; load = 4'b0100; en = 4'b0100; inc = 16'h0300; load_val = 16'h0900;
        tick();
        exp_v = sb.pop_front(); checks++;
        if (observed() !== exp_v || val_w[11:8] !== 4'd0) begin
            failures++; $display("FAIL prio_clr obs=%h exp=%h", observed(), exp_v);
        end
        clr = '0; en = '0;
        tick();
        exp_v = sb.pop_front(); checks++;
        if (observed() !== exp_v || val_w[11:8] !== 4'd9 || nz_w[2] !== 1'b1) begin
            failures++; $display("FAIL prio_load obs=%h exp=%h", observed(), exp_v);
        end
    endtask

    task automatic test_thr();
        clear_inputs();
        thr = 4'd8;
        clr = 4'b1000;
        tick();
        exp_v = sb.pop_front(); checks++;
        if (observed() !== exp_v) begin
            failures++; $display("FAIL thr_clr obs=%h exp=%h", observed(), exp_v);
        end
        clr = '0; en = 4'b1000; inc = 16'h1000;
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp_v = sb.pop_front(); checks++;
            if (observed() !== exp_v || th_w[3] !== (k >= 8)) begin
                failures++; $display("FAIL thr_count%0d obs=%h exp=%h", k, observed(), exp_v);
            end
        end
    endtask

    task automatic test_ovf_clr();
        clear_inputs();
        load = 4'b0001; load_val = 16'h000F;
        tick();
        exp_v = sb.pop_front(); checks++;
        if (observed() !== exp_v || ovf_w[0] !== 1'b1) begin
            failures++; $display("FAIL ovfclr_load obs=%h exp=%h", observed(), exp_v);
        end
        load = '0; en = 4'b0001; inc = 16'h0001; ovf_clr = 4'b0001;
        tick();
        exp_v = sb.pop_front(); checks++;
        if (observed() !== exp_v || ovf_w[0] !== 1'b1 || val_w[3:0] !== 4'd0) begin
            failures++; $display("FAIL ovfclr_setwins obs=%h exp=%h", observed(), exp_v);
        end
        en = '0;
        tick();
        exp_v = sb.pop_front(); checks++;
        if (observed() !== exp_v || ovf_w[0] !== 1'b0) begin
            failures++; $display("FAIL ovfclr_clear obs=%h exp=%h", observed(), exp_v);
        end
    endtask

    task automatic test_async_reset();
        clear_inputs();
        load = 4'b0001; load_val = 16'h000F;
        tick(); exp_v = sb.pop_front();
        load = '0; en = 4'b0001; inc = 16'h0002;
        tick(); exp_v = sb.pop_front();
        en = '0; load = 4'b0001; load_val = 16'h0007;
        tick();
        exp_v = sb.pop_front(); checks++;
        if (observed() !== exp_v || val_w[3:0] !== 4'd7 || ovf_w[0] !== 1'b1) begin
            failures++; $display("FAIL arst_setup obs=%h exp=%h", observed(), exp_v);
        end
        load = '0;
        #2;
        reset_L = 1'b0;
        model_reset();
        #1;
        checks++;
        if (observed() !== expected() || val_w !== '0 || ovf_w !== '0) begin
            failures++; $display("FAIL arst_immediate obs=%h exp=%h", observed(), expected());
        end
        #1;
        reset_L = 1'b1;
        en = 4'b0001; inc = 16'h0001;
        tick();
        exp_v = sb.pop_front(); checks++;
        if (observed() !== exp_v || val_w[3:0] !== 4'd1) begin
            failures++; $display("FAIL arst_first_edge obs=%h exp=%h", observed(), exp_v);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 200; k++) begin
            en       = CH'($urandom);
            dir      = CH'($urandom);
            clr      = CH'($urandom & $urandom & $urandom);
            load     = CH'($urandom & $urandom);
            ovf_clr  = CH'($urandom & $urandom);
            inc      = (CH*IW)'($urandom);
            load_val = (CH*W)'($urandom);
            thr      = W'($urandom);
            tick();
            exp_v = sb.pop_front(); checks++;
            if (observed() !== exp_v) begin
                failures++; $display("FAIL random%0d obs=%h exp=%h", k, observed(), exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_sat();
        test_priority();
        test_thr();
        test_ovf_clr();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/multi_counter.md
MULTI_COUNTER -- requirements
Module: multi_counter

Interface
REQ-001 Parameter WIDTH_P, default 4, counter width in bits per channel (>=2).
REQ-002 Parameter CH_P, default 4, number of independent counter channels (>=1).
REQ-003 Parameter INC_W_P, default 4, increment/decrement step width (1..WIDTH_P).
REQ-004 Parameter SAT_P, default 0, overflow mode: 0 = wrap modulo 2^WIDTH_P, 1 = saturate at 0 / 2^WIDTH_P-1.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset_L  input  1  asynchronous, active-low reset.
REQ-007 en  input  CH_P  per-channel count enable.
REQ-008 dir  input  CH_P  per-channel direction: 0 = up, 1 = down.
REQ-009 inc  input  CH_P*INC_W_P  per-channel step; channel i uses bits [i*INC_W_P +: INC_W_P].
REQ-010 clr  input  CH_P  per-channel synchronous clear.
REQ-011 load  input  CH_P  per-channel synchronous load.
REQ-012 load_val  input  CH_P*WIDTH_P  per-channel load value, packed as for inc.
REQ-013 thr  input  WIDTH_P  threshold shared by all channels.
REQ-014 ovf_clr  input  CH_P  per-channel clear of the sticky overflow flag.
REQ-015 val  output  CH_P*WIDTH_P  registered per-channel count, packed as for inc.
REQ-016 non_zero  output  CH_P  per-channel flag: val[i] != 0.
REQ-017 thr_hit  output  CH_P  per-channel flag: val[i] >= thr (unsigned).
REQ-018 ovf  output  CH_P  per-channel sticky flag: overflow or underflow has occurred.

Function
REQ-019 Channels SHALL be fully independent; no input of channel i affects channel j != i.
REQ-020 Per-channel priority each cycle SHALL be clr > load > en; with none of them asserted, val[i] SHALL hold.
REQ-021 clr[i]=1 SHALL set val[i] to 0 on the next edge, regardless of load[i], en[i] and dir[i].
REQ-022 load[i]=1 (clr[i]=0) SHALL set val[i] to load_val[i] on the next edge.
REQ-023 en[i]=1 (clr[i]=0, load[i]=0) SHALL update val[i] by +inc[i] (dir=0) or -inc[i] (dir=1), latency 1 cycle.
REQ-024 inc[i]=0 with en[i]=1 SHALL leave val[i] unchanged and SHALL NOT set ovf[i].
REQ-025 Up overflow SHALL mean val+inc > 2^WIDTH_P-1; down underflow SHALL mean inc > val; both are evaluated at full precision (WIDTH_P+1 bits).
REQ-026 SAT_P=0: on overflow/underflow, val[i] SHALL take the result modulo 2^WIDTH_P.
REQ-027 SAT_P=1: on overflow, val[i] SHALL become 2^WIDTH_P-1; on underflow, val[i] SHALL become 0.
REQ-028 An overflow or underflow SHALL set ovf[i] on the same edge that updates val[i].
REQ-029 ovf[i] SHALL remain set until ovf_clr[i]=1; if set and clear coincide in one cycle, set SHALL win.
REQ-030 clr and load SHALL NOT affect ovf[i].
REQ-031 non_zero and thr_hit SHALL be combinational from registered val and thr (0 cycles after val changes, no extra flop).

Reset
REQ-032 While reset_L=0, val, ovf SHALL be 0 for all channels asynchronously, so non_zero=0 and thr_hit[i]=(thr==0).
REQ-033 Reset asserted mid-count SHALL discard in-progress state; the first update after release SHALL occur on the first rising edge with reset_L=1.

Verification (WIDTH_P=4, CH_P=4, INC_W_P=4 unless noted)
REQ-034 Reset, then ch0 en=1 dir=0 inc=1 for 20 cycles, SAT_P=0 -> val0 0..15, wraps to 0 at cycle 16, ends at 4; ovf0=1 from cycle 16; other channels stay 0.
REQ-035 SAT_P=1, ch1 load_val=14 then en=1 inc=3 up -> val1 14 -> 15, holds 15, ovf1=1; dir=1 inc=7 -> 8, 1, 0, holds 0.
REQ-036 ch2 clr=1, load=1 (load_val=9) and en=1 in the same cycle -> val2=0; next cycle load=1 only -> val2=9, non_zero2=1.
REQ-037 thr=8, ch3 counting up by 1 from 0 -> thr_hit3 rises in the same cycle val3 becomes 8; thr=0 -> thr_hit=4'b1111 even at reset.
REQ-038 ch0 ovf0=1; ovf_clr0=1 coinciding with a new wrap -> ovf0 stays 1; ovf_clr0=1 alone -> ovf0=0 next cycle.
REQ-039 reset_L pulsed low between edges while val0=7, ovf0=1 -> val0=0, ovf0=0 immediately, with no clock edge needed.
